// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Fixed-latency data memory for the MEM stage of an RV32I pipeline. A load or
//   store request is captured in IDLE, held for LATENCY cycles in ACCESS, and then
//   completed. The following DONE cycle drops busywait for one cycle and
//   presents valid readdata. Loads and stores follow RV32I byte/half/word rules
//   on a little-endian array of 2**ADDR_WIDTH 32-bit words.
//
//   Optional feature macro: DMEM_MISALIGN_CHECK_EN
//     When defined, adds the `misaligned` output. Misaligned requests then leave
//     memory untouched and force load data to zero. When undefined, the
//     offending low address bits are masked.
//
//   Ports
//     clk        in   clock, rising edge
//     reset      in   asynchronous active-low reset
//     read       in   load request
//     write      in   store request (wins over read when both are high)
//     fun_3      in   RV32I funct3 (size / signedness)
//     address    in   byte address (upper bits beyond the array wrap)
//     writedata  in   store data
//     readdata   out  registered load result, held until the next load completes
//     busywait   out  stall request to the pipeline while a request is pending
//     misaligned out  (DMEM_MISALIGN_CHECK_EN only) high during DONE of a misaligned request
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  fun_3,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic        misaligned
`endif
);

    // state  | meaning
    // IDLE   | waiting; busywait follows read|write combinationally
    // ACCESS | counting down the latency on the captured request
    // DONE   | one cycle with busywait low and readdata valid
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic        commit;
    logic        is_byte, is_half;
    logic        mis_eff;
    logic [31:0] word_rd, load_val, store_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_addr;

    assign unused_addr = ^address[31:ADDR_WIDTH+2];

    // Access size depends on direction: store codes other than SB/SH are full
    // word, while for loads bit 2 only selects signedness.
    assign is_byte = wr_q ? (f3_q == 3'b000) : (f3_q[1:0] == 2'b00);
    assign is_half = wr_q ? (f3_q == 3'b001) : (f3_q[1:0] == 2'b01);

    assign commit  = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign word_rd = mem[idx_q];

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    assign mis_eff      = (is_half && off_q[0]) || (!is_byte && !is_half && (off_q != 2'b00));
    assign misaligned_d = commit && mis_eff;
    assign misaligned   = misaligned_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misaligned_q <= 1'b0;
        else        misaligned_q <= misaligned_d;
    end
`else
    assign mis_eff = 1'b0;
`endif

    always_comb begin
        byte_sel = word_rd[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? word_rd[31:16] : word_rd[15:0];
        if (is_byte)      load_val = f3_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (is_half) load_val = f3_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        else              load_val = word_rd;
    end

    always_comb begin
        store_val = word_rd;
        if (is_byte)      store_val[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
        else if (is_half) store_val[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else              store_val                            = wdata_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit && rd_q && !wr_q) rdata_d = mis_eff ? 32'd0 : load_val;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        busywait = 1'b0;
        case (state_q)
            S_IDLE: begin
                busywait = read | write;
                if (read | write) begin
                    idx_d   = address[ADDR_WIDTH+1:2];
                    off_d   = address[1:0];
                    wdata_d = writedata;
                    f3_d    = fun_3;
                    rd_d    = read;
                    wr_d    = write;
                    cnt_d   = CNT_INIT;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                busywait = 1'b1;
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Keeps busywait low while reset is held even if a request is on the inputs.
        busywait = busywait & reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            wdata_q <= 32'd0;
            f3_q    <= 3'b000;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset. An asynchronous reset forces IDLE, so commit is low and
    // an interrupted store is dropped.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !mis_eff) mem[idx_q] <= store_val;
    end

    assign readdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read, write;
    logic [2:0]  fun_3;
    logic [31:0] address, writedata;
    logic [31:0] readdata;
    logic        busywait;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int errors = 0;
    int checks = 0;

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .read      (read),
        .write     (write),
        .fun_3     (fun_3),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        .misaligned(misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: byte array + request timeline ----------------
    logic [7:0]  m_mem [0:1023];
    int          cyc = 0;
    int          m_start;
    bit          m_busy = 0, m_done = 0, m_mis = 0;
    logic [31:0] m_rdata = 32'd0;
    logic        c_rd, c_wr;
    logic [2:0]  c_f;
    logic [31:0] c_a, c_wd;

    function automatic int base_of(input logic [31:0] a);
        return int'(a[9:2]) * 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a);
        int b = base_of(a);
        logic [7:0]  by;
        logic [15:0] h;
        case (f)
            3'b000, 3'b100: begin
                by = m_mem[b + int'(a[1:0])];
                return f[2] ? {24'd0, by} : {{24{by[7]}}, by};
            end
            3'b001, 3'b101: begin
                h = {m_mem[b + (a[1] ? 3 : 1)], m_mem[b + (a[1] ? 2 : 0)]};
                return f[2] ? {16'd0, h} : {{16{h[15]}}, h};
            end
            default: return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
        endcase
    endfunction

    task automatic m_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int b = base_of(a);
        if (f == 3'b000) m_mem[b + int'(a[1:0])] = d[7:0];
        else if (f == 3'b001) begin
            m_mem[b + (a[1] ? 2 : 0)] = d[7:0];
            m_mem[b + (a[1] ? 3 : 1)] = d[15:8];
        end else begin
            for (int k = 0; k < 4; k++) m_mem[b + k] = d[8*k +: 8];
        end
    endtask

    function automatic bit m_misal(input logic w, input logic [2:0] f, input logic [31:0] a);
        int sz;
        if (w) sz = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
        else   sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
`ifdef DMEM_MISALIGN_CHECK_EN
        return (int'(a[1:0]) % sz) != 0;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        logic exp_bw;
        bit   mis;
        cyc++;
        if (!rst_n) begin
            chk("rst_busywait", {31'd0, busywait}, 32'd0);
            chk("rst_readdata", readdata, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
            chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
`endif
            m_busy  = 0;
            m_done  = 0;
            m_mis   = 0;
            m_rdata = 32'd0;
        end else begin
            exp_bw = m_busy ? 1'b1 : (m_done ? 1'b0 : (read | write));
            chk("model_busywait", {31'd0, busywait}, {31'd0, exp_bw});
            chk("model_readdata", readdata, m_rdata);
`ifdef DMEM_MISALIGN_CHECK_EN
            chk("model_misaligned", {31'd0, misaligned}, {31'd0, m_done && m_mis});
`endif
            if (m_busy && cyc == m_start + LAT) begin
                mis    = m_misal(c_wr, c_f, c_a);
                m_mis  = mis;
                if (c_wr) begin
                    if (!mis) m_store(c_f, c_a, c_wd);
                end else if (c_rd) begin
                    m_rdata = mis ? 32'd0 : m_load(c_f, c_a);
                end
                m_busy = 0;
                m_done = 1;
            end else if (m_done) begin
                m_done = 0;
            end else if (!m_busy && (read | write)) begin
                c_rd = read; c_wr = write; c_f = fun_3; c_a = address; c_wd = writedata;
                m_busy  = 1;
                m_start = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // Drives a request, scrambles inputs during ACCESS, returns on the DONE negedge.
    task automatic req(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, output int nbusy);
        bit done = 0;
        nbusy = 0;
        read = r; write = w; fun_3 = f; address = a; writedata = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busywait) begin
                nbusy++;
                @(posedge clk); #1;
                read = 1'b0; write = 1'b0; fun_3 = 3'b111;
                address = 32'hFFFF_FFFF; writedata = 32'h0;
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL req_timeout: busywait stuck high for addr %h", a);
        end
    endtask

    task automatic access(input string name, input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit check_rd, input logic [31:0] exp_rd, input bit exp_mis);
        int nb;
        req(r, w, f, a, wd, nb);
        chk({name, "_busylen"}, nb, LAT + 1);
        if (check_rd) chk(name, readdata, exp_rd);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk({name, "_mis"}, {31'd0, misaligned}, {31'd0, exp_mis});
`else
        if (exp_mis) chk({name, "_mis_unexpected"}, 32'd1, 32'd0);
`endif
        idle_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        rst_n = 1'b0; read = 0; write = 0; fun_3 = 0; address = 0; writedata = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle_cycle();
        chk("reset_busywait", {31'd0, busywait}, 32'd0);
        chk("reset_readdata", readdata, 32'd0);

        access("sw_dead",  0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        access("lw_dead",  1, 0, 3'b010, 32'h10, 0, 1, 32'hDEADBEEF, 0);

        access("sw_base",  0, 1, 3'b010, 32'h10, 32'h11223344, 0, 0, 0);
        access("sb_80",    0, 1, 3'b000, 32'h13, 32'hABCDEF80, 0, 0, 0);
        access("lw_after_sb", 1, 0, 3'b010, 32'h10, 0, 1, 32'h80223344, 0);
        access("lb_13",    1, 0, 3'b000, 32'h13, 0, 1, 32'hFFFFFF80, 0);
        access("lbu_13",   1, 0, 3'b100, 32'h13, 0, 1, 32'h00000080, 0);

        access("sw_cafe",  0, 1, 3'b010, 32'h20, 32'hCAFE1234, 0, 0, 0);
        access("sh_8001",  0, 1, 3'b001, 32'h22, 32'h55558001, 0, 0, 0);
        access("lh_22",    1, 0, 3'b001, 32'h22, 0, 1, 32'hFFFF8001, 0);
        access("lhu_22",   1, 0, 3'b101, 32'h22, 0, 1, 32'h00008001, 0);
        access("lw_20",    1, 0, 3'b010, 32'h20, 0, 1, 32'h80011234, 0);

        // read held through DONE: one access, then a fresh one on the next IDLE
        read = 1; write = 0; fun_3 = 3'b010; address = 32'h10;
        n = 0; ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busywait) begin ok = 1; break; end
            n++;
        end
        chk("hold_busylen", n, LAT + 1);
        chk("hold_readdata", readdata, 32'h80223344);
        chk("hold_done_seen", {31'd0, ok}, 32'd1);
        idle_cycle();
        @(negedge clk);
        chk("hold_restart", {31'd0, busywait}, 32'd1);
        @(posedge clk); #1 read = 0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busywait) begin ok = 1; break; end
        end
        chk("hold_second_done", {31'd0, ok}, 32'd1);
        idle_cycle();

        // read+write together act as a store; readdata untouched
        access("lw_pre_rw", 1, 0, 3'b010, 32'h20, 0, 1, 32'h80011234, 0);
        access("rw_store",  1, 1, 3'b010, 32'h30, 32'h0BADF00D, 1, 32'h80011234, 0);
        access("lw_30",     1, 0, 3'b010, 32'h30, 0, 1, 32'h0BADF00D, 0);

        // upper address bits wrap onto the same word
        access("sw_wrap",  0, 1, 3'b010, 32'hFFFF0434, 32'h13572468, 0, 0, 0);
        access("lw_wrap",  1, 0, 3'b010, 32'h34, 0, 1, 32'h13572468, 0);

`ifdef DMEM_MISALIGN_CHECK_EN
        access("lw_mis",   1, 0, 3'b010, 32'h11, 0, 1, 32'h00000000, 1);
        access("sw_mis",   0, 1, 3'b010, 32'h12, 32'h99999999, 0, 0, 1);
        access("lh_mis",   1, 0, 3'b001, 32'h23, 0, 1, 32'h00000000, 1);
        access("lw_unchg", 1, 0, 3'b010, 32'h10, 0, 1, 32'h80223344, 0);
`else
        access("lw_mask",  1, 0, 3'b010, 32'h11, 0, 1, 32'h80223344, 0);
        access("lh_mask",  1, 0, 3'b001, 32'h23, 0, 1, 32'hFFFF8001, 0);
`endif

        // reset mid-ACCESS drops the store
        access("sw_1111",  0, 1, 3'b010, 32'h40, 32'h11111111, 0, 0, 0);
        access("lw_1111",  1, 0, 3'b010, 32'h40, 0, 1, 32'h11111111, 0);
        read = 0; write = 1; fun_3 = 3'b010; address = 32'h40; writedata = 32'h22222222;
        @(posedge clk); #1 write = 0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("midrst_busywait", {31'd0, busywait}, 32'd0);
        chk("midrst_readdata", readdata, 32'd0);
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        idle_cycle();
        chk("postrst_idle_bw", {31'd0, busywait}, 32'd0);
        access("lw_after_rst", 1, 0, 3'b010, 32'h40, 0, 1, 32'h11111111, 0);

        repeat (2) idle_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
